// File: rtl/aes_inv_ctrl_pkg.sv
// Shared AES inverse-cipher definitions: datapath step codes and default round count.
// The round datapath imports the same package so both ends agree on the cs encoding.
package aes_inv_defs;

    localparam logic [2:0] CS_RES = 3'b000;
    localparam logic [2:0] CS_STL = 3'b001;
    localparam logic [2:0] CS_ADD = 3'b010;
    localparam logic [2:0] CS_SUB = 3'b011;
    localparam logic [2:0] CS_SHI = 3'b100;
    localparam logic [2:0] CS_MIX = 3'b101;
    localparam logic [2:0] CS_INV = 3'b110;
    localparam logic [2:0] CS_FIN = 3'b111;

    localparam int NR_DEFAULT = 10;

endpackage

// File: rtl/aes_inv_round_cnt.sv
// Round index counter: loads the round count, steps down once per round, never wraps.
// last_round flags the final (MIX-less) round.
module aes_inv_round_cnt #(
    parameter logic [7:0] LOAD_VAL = 8'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    output logic [7:0] count,
    output logic       last_round
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign last_round = (count == 8'd1);

endmodule

// File: rtl/aes_inv_ctrl.sv
// Sequencer for the AES inverse-cipher round datapath (cs/count/sel_in plus start/busy/done).
// Optional freeze input enabled by defining AES_INV_STALL_EN.
module aes_inv_ctrl
    import aes_inv_defs::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef AES_INV_STALL_EN
    input  logic       stall,
`endif
    output logic [2:0] cs,
    output logic [7:0] count,
    output logic       sel_in,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ADD0,
        S_SHI,
        S_SUB,
        S_INV,
        S_ADD,
        S_MIX,
        S_DONE
    } state_t;

    localparam logic [7:0] NR_VAL = 8'(NR);

    state_t state;
    logic   stall_act;
    logic   cnt_load;
    logic   cnt_dec;
    logic   last_round;

`ifdef AES_INV_STALL_EN
    assign stall_act = stall && (state != S_IDLE);
`else
    assign stall_act = 1'b0;
`endif

    // Counter moves on the same edge as the state transitions that end a round.
    assign cnt_load = (state == S_IDLE) && start;
    assign cnt_dec  = !stall_act && ((state == S_MIX) || ((state == S_ADD) && last_round));

    aes_inv_round_cnt #(
        .LOAD_VAL (NR_VAL)
    ) u_round_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .count      (count),
        .last_round (last_round)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cs     <= CS_FIN;
            sel_in <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            sel_in <= 1'b0;
            done   <= 1'b0;
            if (stall_act) begin
                // Frozen cycle: datapath holds, state resumes from where it was.
                cs <= CS_FIN;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state  <= S_LOAD;
                            cs     <= CS_RES;
                            sel_in <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            cs   <= CS_FIN;
                            busy <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        state <= S_ADD0;
                        cs    <= CS_ADD;
                    end
                    S_ADD0, S_MIX: begin
                        state <= S_SHI;
                        cs    <= CS_SHI;
                    end
                    S_SHI: begin
                        state <= S_SUB;
                        cs    <= CS_SUB;
                    end
                    S_SUB: begin
                        state <= S_INV;
                        cs    <= CS_INV;
                    end
                    S_INV: begin
                        state <= S_ADD;
                        cs    <= CS_ADD;
                    end
                    S_ADD: begin
                        if (last_round) begin
                            state <= S_DONE;
                            cs    <= CS_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_MIX;
                            cs    <= CS_MIX;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        cs    <= CS_FIN;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        cs    <= CS_FIN;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
